qam_symbol_scheduler: RTL and testbench



---
 rtl/qam_pkg.sv | 16 +
 rtl/qam_baud_timer.sv | 44 ++++
 rtl/qam_symbol_scheduler.sv | 132 +++++++++++++
 tb/tb_qam_symbol_scheduler.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qam_pkg.sv
// Shared types and default constants for the QAM symbol scheduler slice.
package qam_pkg;

    localparam int DEF_BITS_PER_SYM = 4;
    localparam int DEF_CLK_DIV      = 512;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_e;

    typedef logic [DEF_BITS_PER_SYM-1:0] sym_t;

endpackage

// File: rtl/qam_baud_timer.sv
// Symbol-period timer: free-running modulo-CLK_DIV counter with a registered
// one-cycle tick at the end of each period.
module qam_baud_timer #(
    parameter int CLK_DIV = 512
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] count_q, count_d;
    logic          tick_q, tick_d;

    // The tick is registered, so the first period boundary after a start
    // lands CLK_DIV+1 edges later while later ones stay CLK_DIV apart.
    always_comb begin
        count_d = count_q;
        tick_d  = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            tick_d  = (count_q == LAST);
            count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tick_q  <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/qam_symbol_scheduler.sv
// Paces the serial bit source, packs bits into symbols and releases one
// symbol per period to the I/Q mapper with underrun detection and counting.
module qam_symbol_scheduler
    import qam_pkg::*;
#(
    parameter int CLK_DIV      = DEF_CLK_DIV,
    parameter int BITS_PER_SYM = DEF_BITS_PER_SYM,
    parameter int CNT_W        = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    stop,
    output logic                    bit_req,
    input  logic                    bit_in,
    input  logic                    bit_valid,
    output logic [BITS_PER_SYM-1:0] sym_out,
    output logic                    sym_strobe,
    output logic                    busy,
    output logic                    underrun,
    output logic [CNT_W-1:0]        sym_count,
    output state_e                  dbg_state
);

    localparam int IW = $clog2(BITS_PER_SYM + 1);
    localparam logic [IW-1:0] FULL = IW'(BITS_PER_SYM);

    state_e                  state_q, state_d;
    logic [BITS_PER_SYM-1:0] stage_q, stage_d;
    logic [BITS_PER_SYM-1:0] sym_q, sym_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [IW-1:0]           idx_inc;
    logic                    strobe_q, strobe_d;
    logic                    under_q, under_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    tick;
    logic                    busy_w;

    assign busy_w  = (state_q != IDLE);
    assign idx_inc = idx_q + 1'b1;

    qam_baud_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (!busy_w),
        .enable (busy_w),
        .tick   (tick)
    );

    always_comb begin
        state_d  = state_q;
        stage_d  = stage_q;
        sym_d    = sym_q;
        idx_d    = idx_q;
        strobe_d = 1'b0;
        under_d  = under_q;
        count_d  = count_q;

        if (stop && busy_w) begin
            // Abort: partial symbol is dropped, delivered outputs hold.
            state_d = IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    idx_d = '0;
                    if (start && !stop) begin
                        state_d = REQ;
                        under_d = 1'b0;
                    end
                end
                REQ: begin
                    state_d = WAIT;
                end
                WAIT: begin
                    if (bit_valid) begin
                        stage_d = {stage_q[BITS_PER_SYM-2:0], bit_in};
                        idx_d   = idx_inc;
                        state_d = (idx_inc == FULL) ? HOLD : REQ;
                    end
                end
                HOLD: begin
                    if (tick) begin
                        sym_d    = stage_q;
                        strobe_d = 1'b1;
                        count_d  = count_q + 1'b1;
                        idx_d    = '0;
                        state_d  = REQ;
                    end
                end
                default: state_d = IDLE;
            endcase

            // Period ended mid-fill: repeat the old symbol, keep filling.
            if (tick && (state_q == REQ || state_q == WAIT)) begin
                under_d  = 1'b1;
                strobe_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            stage_q  <= '0;
            sym_q    <= '0;
            idx_q    <= '0;
            strobe_q <= 1'b0;
            under_q  <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            stage_q  <= stage_d;
            sym_q    <= sym_d;
            idx_q    <= idx_d;
            strobe_q <= strobe_d;
            under_q  <= under_d;
            count_q  <= count_d;
        end
    end

    assign bit_req    = (state_q == REQ);
    assign busy       = busy_w;
    assign sym_out    = sym_q;
    assign sym_strobe = strobe_q;
    assign underrun   = under_q;
    assign sym_count  = count_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_qam_symbol_scheduler.sv
// Directed bench for qam_symbol_scheduler with a latency-programmable bit source.
module tb_qam_symbol_scheduler;
    import qam_pkg::*;

    localparam int CLK_DIV = 16;
    localparam int BPS     = 4;
    localparam int CNT_W   = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic             stop;
    logic             bit_req;
    logic             bit_in;
    logic             bit_valid;
    logic [BPS-1:0]   sym_out;
    logic             sym_strobe;
    logic             busy;
    logic             underrun;
    logic [CNT_W-1:0] sym_count;
    state_e           dbg_state;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int req_total    = 0;
    int last_cyc     = 0;
    int last_req     = 0;

    logic [15:0] seq_v = 16'b0110_1100_1100_0001;
    int src_ptr = 0;
    int src_lat = 1;
    int src_cnt = 0;

    qam_symbol_scheduler #(
        .CLK_DIV      (CLK_DIV),
        .BITS_PER_SYM (BPS),
        .CNT_W        (CNT_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .bit_req    (bit_req),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .sym_out    (sym_out),
        .sym_strobe (sym_strobe),
        .busy       (busy),
        .underrun   (underrun),
        .sym_count  (sym_count),
        .dbg_state  (dbg_state)
    );

    // clock / reset block
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    always @(posedge clock) if (bit_req === 1'b1) req_total <= req_total + 1;

    // bit source: answers each bit_req src_lat cycles later
    initial begin
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            bit_valid = 1'b0;
            if (src_cnt > 0) begin
                src_cnt--;
                if (src_cnt == 0) begin
                    bit_valid = 1'b1;
                    bit_in    = seq_v[15-src_ptr];
                    src_ptr   = (src_ptr + 1) % 16;
                end
            end
            if (bit_req === 1'b1) src_cnt = src_lat;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // driver tasks
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
        last_cyc = cyc;
        last_req = req_total;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
    endtask

    task automatic wait_strobe(output int interval, output int reqs, output bit ok);
        ok       = 1'b0;
        interval = -1;
        reqs     = -1;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (sym_strobe === 1'b1) begin
                ok       = 1'b1;
                interval = cyc - last_cyc;
                reqs     = req_total - last_req;
                last_cyc = cyc;
                last_req = req_total;
                break;
            end
        end
    endtask

    // scenarios
    task automatic test_reset();
        reset = 1'b1;
        step(3);
        tests_run++;
        if (bit_req !== 1'b0 || sym_strobe !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: bit_req=%b strobe=%b busy=%b, want 0 0 0", bit_req, sym_strobe, busy);
        end
        tests_run++;
        if (sym_out !== 4'h0 || sym_count !== 4'h0 || underrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_data: sym_out=%h count=%0d underrun=%b, want 0 0 0", sym_out, sym_count, underrun);
        end
        tests_run++;
        if (dbg_state !== IDLE) begin
            tests_failed++;
            $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE);
        end
        reset = 1'b0;
        step(1);
    endtask

    task automatic test_nominal();
        logic [3:0] exp_sym [4];
        int iv, rq;
        bit ok;
        exp_sym = '{4'b0110, 4'b1100, 4'b1100, 4'b0001};
        src_ptr = 0;
        src_lat = 1;
        pulse_start();
        for (int k = 0; k < 4; k++) begin
            wait_strobe(iv, rq, ok);
            tests_run++;
            if (!ok || iv != ((k == 0) ? CLK_DIV + 1 : CLK_DIV)) begin
                tests_failed++;
                $display("FAIL nominal_interval[%0d]: got %0d want %0d", k, iv, (k == 0) ? CLK_DIV + 1 : CLK_DIV);
            end
            tests_run++;
            if (sym_out !== exp_sym[k] || sym_count !== 4'(k + 1) || underrun !== 1'b0) begin
                tests_failed++;
                $display("FAIL nominal_sym[%0d]: sym=%b count=%0d underrun=%b, want %b %0d 0",
                         k, sym_out, sym_count, underrun, exp_sym[k], k + 1);
            end
            tests_run++;
            if (rq != BPS) begin
                tests_failed++;
                $display("FAIL nominal_reqs[%0d]: got %0d want %0d", k, rq, BPS);
            end
            step(1);
            tests_run++;
            if (sym_strobe !== 1'b0) begin
                tests_failed++;
                $display("FAIL nominal_strobe_width[%0d]: got %b want 0", k, sym_strobe);
            end
        end
    endtask

    task automatic test_start_busy();
        int iv, rq;
        bit ok;
        step(4);
        pulse_start();
        last_cyc = last_cyc - 6;
        wait_strobe(iv, rq, ok);
        tests_run++;
        if (!ok || iv != CLK_DIV || sym_out !== 4'b0110 || sym_count !== 4'd5) begin
            tests_failed++;
            $display("FAIL start_busy: interval=%0d sym=%b count=%0d, want %0d 0110 5", iv, sym_out, sym_count, CLK_DIV);
        end
    endtask

    task automatic test_start_stop_same();
        int r0;
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || sym_out !== 4'b0110 || sym_count !== 4'd5) begin
            tests_failed++;
            $display("FAIL stop_hold: busy=%b sym=%b count=%0d, want 0 0110 5", busy, sym_out, sym_count);
        end
        step(3);
        r0    = req_total;
        start = 1'b1;
        stop  = 1'b1;
        step(1);
        start = 1'b0;
        stop  = 1'b0;
        step(3);
        tests_run++;
        if (busy !== 1'b0 || dbg_state !== IDLE || req_total != r0) begin
            tests_failed++;
            $display("FAIL start_stop_same: busy=%b state=%0d reqs=%0d, want 0 %0d 0", busy, dbg_state, IDLE, req_total - r0);
        end
    endtask

    task automatic test_reset_mid_wait();
        bit bad;
        src_ptr = 0;
        src_lat = 3;
        pulse_start();
        step(1);
        tests_run++;
        if (dbg_state !== WAIT) begin
            tests_failed++;
            $display("FAIL midwait_state: got %0d want %0d", dbg_state, WAIT);
        end
        pulse_reset();
        tests_run++;
        if (bit_req !== 1'b0 || sym_out !== 4'h0 || sym_strobe !== 1'b0 || busy !== 1'b0 ||
            underrun !== 1'b0 || sym_count !== 4'h0) begin
            tests_failed++;
            $display("FAIL midwait_reset: req=%b sym=%h strobe=%b busy=%b under=%b count=%0d, want all 0",
                     bit_req, sym_out, sym_strobe, busy, underrun, sym_count);
        end
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            if (busy !== 1'b0 || bit_req !== 1'b0 || sym_count !== 4'h0) bad = 1'b1;
        end
        tests_run++;
        if (bad) begin
            tests_failed++;
            $display("FAIL midwait_late_bit: busy=%b req=%b count=%0d, want 0 0 0", busy, bit_req, sym_count);
        end
    endtask

    task automatic test_slow_underrun();
        int iv, rq;
        bit ok;
        pulse_reset();
        step(2);
        src_ptr = 0;
        src_lat = 5;
        pulse_start();
        wait_strobe(iv, rq, ok);
        tests_run++;
        if (!ok || iv != CLK_DIV + 1 || sym_out !== 4'b0000 || underrun !== 1'b1 || sym_count !== 4'd0) begin
            tests_failed++;
            $display("FAIL slow_first: interval=%0d sym=%b under=%b count=%0d, want 17 0000 1 0",
                     iv, sym_out, underrun, sym_count);
        end
        wait_strobe(iv, rq, ok);
        tests_run++;
        if (!ok || iv != CLK_DIV || sym_out !== 4'b0110 || underrun !== 1'b1 || sym_count !== 4'd1) begin
            tests_failed++;
            $display("FAIL slow_second: interval=%0d sym=%b under=%b count=%0d, want 16 0110 1 1",
                     iv, sym_out, underrun, sym_count);
        end
    endtask

    task automatic test_stop_restart();
        int iv, rq;
        bit ok;
        step(12);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || sym_out !== 4'b0110 || sym_count !== 4'd1 || underrun !== 1'b1) begin
            tests_failed++;
            $display("FAIL stop_mid_fill: busy=%b sym=%b count=%0d under=%b, want 0 0110 1 1",
                     busy, sym_out, sym_count, underrun);
        end
        step(10);
        src_lat = 1;
        pulse_start();
        tests_run++;
        if (underrun !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL restart_clear: under=%b busy=%b, want 0 1", underrun, busy);
        end
        wait_strobe(iv, rq, ok);
        tests_run++;
        if (!ok || iv != CLK_DIV + 1 || sym_out !== 4'b0110 || sym_count !== 4'd2 || underrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL restart_sym: interval=%0d sym=%b count=%0d under=%b, want 17 0110 2 0",
                     iv, sym_out, sym_count, underrun);
        end
    endtask

    task automatic test_wrap();
        int iv, rq;
        bit ok;
        int bad;
        pulse_reset();
        step(3);
        src_ptr = 0;
        src_lat = 1;
        pulse_start();
        bad = 0;
        for (int k = 0; k < (1 << CNT_W) + 3; k++) begin
            wait_strobe(iv, rq, ok);
            if (!ok || iv != ((k == 0) ? CLK_DIV + 1 : CLK_DIV)) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL wrap_cadence: %0d bad intervals, want 0", bad);
        end
        tests_run++;
        if (sym_count !== 4'd3 || sym_out !== 4'b1100 || underrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL wrap_count: count=%0d sym=%b under=%b, want 3 1100 0", sym_count, sym_out, underrun);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        test_reset();
        test_nominal();
        test_start_busy();
        test_start_stop_same();
        test_reset_mid_wait();
        test_slow_underrun();
        test_stop_restart();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
